// File: rtl/cpu_ctrl_if.sv
// Bundle between cpu_ctrl and its neighbours: instruction ROM, UART/interrupt glue, execute unit.
// master = controller side, slave = environment side.
interface cpu_ctrl_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int OPC_W  = 4,
   parameter int IMM_W  = 12,
   parameter int UART_W = 8
);
   // instruction ROM
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;

   // receive / transmit side
   logic              irr;
   logic [UART_W-1:0] rx_data;
   logic              ack;
   logic              tx_req;
   logic [UART_W-1:0] tx_data;
   logic              tx_busy;

   // decoded instruction towards the execute unit
   logic [OPC_W-1:0]  de_opcode;
   logic [IMM_W-1:0]  de_imm;
   logic              de_irr;
   logic [UART_W-1:0] de_rx_data;
   logic              de_valid;

   // next architectural state returned by the execute unit
   logic              ex_done;
   logic [ADDR_W-1:0] ex_pc;
   logic              ex_ack;
   logic              ex_tx_req;
   logic [UART_W-1:0] ex_tx_data;

   modport master (
      output rom_addr,
      input  rom_data,
      input  irr,
      input  rx_data,
      output ack,
      output tx_req,
      output tx_data,
      input  tx_busy,
      output de_opcode,
      output de_imm,
      output de_irr,
      output de_rx_data,
      output de_valid,
      input  ex_done,
      input  ex_pc,
      input  ex_ack,
      input  ex_tx_req,
      input  ex_tx_data
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      output irr,
      output rx_data,
      input  ack,
      input  tx_req,
      input  tx_data,
      output tx_busy,
      input  de_opcode,
      input  de_imm,
      input  de_irr,
      input  de_rx_data,
      input  de_valid,
      output ex_done,
      output ex_pc,
      output ex_ack,
      output ex_tx_req,
      output ex_tx_data
   );
endinterface

// File: rtl/cpu_ctrl.sv
// Fetch/decode/execute/writeback sequencer for the microcoded CPU; commits execute-unit results.
// Optional CPU_CTRL_TX_STALL_EN: hold WRITEBACK while a pending tx_req meets a busy transmitter.
module cpu_ctrl #(
   parameter int ADDR_W  = 11,
   parameter int DATA_W  = 32,
   parameter int OPC_W   = 4,
   parameter int IMM_W   = 12,
   parameter int ROM_LAT = 1,
   parameter int UART_W  = 8
) (
   input  logic        clk,
   input  logic        reset,
   cpu_ctrl_if.master  bus,
   output logic [1:0]  phase,
   output logic [31:0] retired
);

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      DECODE    = 2'd1,
      EXECUTE   = 2'd2,
      WRITEBACK = 2'd3
   } state_t;

   localparam int          LAT_W    = 2;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 1);

   state_t            state_q, state_d;
   logic [LAT_W-1:0]  lat_q;

   logic [ADDR_W-1:0] pc_q;
   logic              ack_q;
   logic              tx_req_q;
   logic [UART_W-1:0] tx_data_q;
   logic [31:0]       retired_q;

   logic [OPC_W-1:0]  de_opcode_q;
   logic [IMM_W-1:0]  de_imm_q;
   logic              de_irr_q;
   logic [UART_W-1:0] de_rx_data_q;
   logic              de_valid_q;

   logic [ADDR_W-1:0] pend_pc_q;
   logic              pend_ack_q;
   logic              pend_tx_req_q;
   logic [UART_W-1:0] pend_tx_data_q;

   logic              stall;
   logic              fetch_done;
   logic              ex_accept;
   logic              commit;

`ifdef CPU_CTRL_TX_STALL_EN
   assign stall = pend_tx_req_q & bus.tx_busy;
   logic unused_bits;
   assign unused_bits = ^bus.rom_data[DATA_W-IMM_W-1:OPC_W];
`else
   assign stall = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{bus.rom_data[DATA_W-IMM_W-1:OPC_W], bus.tx_busy};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_done = 1'b0;
      ex_accept  = 1'b0;
      commit     = 1'b0;
      case (state_q)
         FETCH: begin
            if (lat_q == LAT_LAST) begin
               fetch_done = 1'b1;
               state_d    = DECODE;
            end
         end
         DECODE: begin
            state_d = EXECUTE;
         end
         EXECUTE: begin
            if (bus.ex_done) begin
               ex_accept = 1'b1;
               state_d   = WRITEBACK;
            end
         end
         WRITEBACK: begin
            if (!stall) begin
               commit  = 1'b1;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   // ROM latency counter; idles at zero outside FETCH so each fetch starts fresh
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_q <= '0;
      end else if (state_q == FETCH && !fetch_done) begin
         lat_q <= lat_q + 1'b1;
      end else begin
         lat_q <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         de_opcode_q  <= '0;
         de_imm_q     <= '0;
         de_irr_q     <= 1'b0;
         de_rx_data_q <= '0;
      end else if (state_q == DECODE) begin
         de_opcode_q  <= bus.rom_data[OPC_W-1:0];
         de_imm_q     <= bus.rom_data[DATA_W-1 -: IMM_W];
         de_irr_q     <= bus.irr;
         de_rx_data_q <= bus.rx_data;
      end
   end

   // high exactly on the first EXECUTE cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         de_valid_q <= 1'b0;
      end else begin
         de_valid_q <= (state_q == DECODE);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_pc_q      <= '0;
         pend_ack_q     <= 1'b0;
         pend_tx_req_q  <= 1'b0;
         pend_tx_data_q <= '0;
      end else if (ex_accept) begin
         pend_pc_q      <= bus.ex_pc;
         pend_ack_q     <= bus.ex_ack;
         pend_tx_req_q  <= bus.ex_tx_req;
         pend_tx_data_q <= bus.ex_tx_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q      <= '0;
         ack_q     <= 1'b0;
         tx_req_q  <= 1'b0;
         tx_data_q <= '0;
         retired_q <= '0;
      end else if (commit) begin
         pc_q      <= pend_pc_q;
         ack_q     <= pend_ack_q;
         tx_req_q  <= pend_tx_req_q;
         tx_data_q <= pend_tx_data_q;
         retired_q <= retired_q + 32'd1;
      end
   end

   assign bus.rom_addr   = pc_q;
   assign bus.ack        = ack_q;
   assign bus.tx_req     = tx_req_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.de_opcode  = de_opcode_q;
   assign bus.de_imm     = de_imm_q;
   assign bus.de_irr     = de_irr_q;
   assign bus.de_rx_data = de_rx_data_q;
   assign bus.de_valid   = de_valid_q;
   assign phase          = state_q;
   assign retired        = retired_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: scoreboarded commits on a ROM_LAT=1 core, decode timing on a ROM_LAT=3 core.
module tb_cpu_ctrl;

`ifdef CPU_CTRL_TX_STALL_EN
   localparam bit STALL = 1'b1;
`else
   localparam bit STALL = 1'b0;
`endif

   typedef struct {
      logic [10:0] pc;
      logic        ack;
      logic        txr;
      logic [7:0]  txd;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        reset3 = 1'b0;
   logic [1:0]  ph, ph3;
   logic [31:0] ret, ret3;
   logic [31:0] rom_q;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   exp_t        sb[$];
   logic [10:0] cur_pc;
   logic        cur_ack, cur_txr;
   logic [7:0]  cur_txd;
   int          ret_exp;

   cpu_ctrl_if b ();
   cpu_ctrl_if b3 ();

   cpu_ctrl #(.ROM_LAT(1)) dut (.clk(clk), .reset(reset), .bus(b.master), .phase(ph), .retired(ret));
   cpu_ctrl #(.ROM_LAT(3)) dut3 (.clk(clk), .reset(reset3), .bus(b3.master), .phase(ph3), .retired(ret3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rom_word(input logic [10:0] a);
      return {({1'b1, a} ^ 12'h35A), 16'h0000, (a[3:0] ^ 4'h9)};
   endfunction

   // one-cycle ROM model
   always @(posedge clk) rom_q <= rom_word(b.rom_addr);
   assign b.rom_data = rom_q;

   // ROM_LAT=3 core: constant ROM word, execute unit answers on de_valid
   assign b3.rom_data   = 32'hABC0_0005;
   assign b3.irr        = 1'b0;
   assign b3.rx_data    = 8'h00;
   assign b3.tx_busy    = 1'b0;
   assign b3.ex_done    = b3.de_valid;
   assign b3.ex_pc      = b3.rom_addr + 11'd1;
   assign b3.ex_ack     = 1'b0;
   assign b3.ex_tx_req  = 1'b0;
   assign b3.ex_tx_data = 8'h00;

   task automatic run_instr(input int delay, input logic [10:0] npc, input logic nack,
                            input logic ntxr, input logic [7:0] ntxd, input int busy,
                            input bit junk, output int dv_cyc);
      exp_t        e;
      logic [31:0] w;
      int          guard, ex_cnt, dv_cnt, wb_cnt, wb_exp;
      logic        irr_v;
      logic [7:0]  rx_v;
      irr_v     = ($urandom_range(0, 1) == 1);
      rx_v      = 8'($urandom_range(0, 255));
      b.irr     = irr_v;
      b.rx_data = rx_v;
      b.ex_done = junk;
      b.ex_pc   = ~npc;
      b.ex_ack  = ~nack;
      b.ex_tx_req  = ~ntxr;
      b.ex_tx_data = ~ntxd;
      w = rom_word(cur_pc);
      guard = 0;
      while (b.de_valid !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      dv_cyc = cyc;
      checks++;
      if (guard >= 40) begin
         failures++;
         $display("FAIL de_valid_timeout: no de_valid within %0d cycles", guard);
         b.ex_done = 1'b0;
         return;
      end
      // first EXECUTE cycle
      checks++;
      if (b.de_opcode !== w[3:0]) begin
         failures++;
         $display("FAIL de_opcode: got %h want %h", b.de_opcode, w[3:0]);
      end
      checks++;
      if (b.de_imm !== w[31:20]) begin
         failures++;
         $display("FAIL de_imm: got %h want %h", b.de_imm, w[31:20]);
      end
      checks++;
      if (b.de_irr !== irr_v || b.de_rx_data !== rx_v) begin
         failures++;
         $display("FAIL de_rx: got irr=%b rx=%h want irr=%b rx=%h", b.de_irr, b.de_rx_data, irr_v, rx_v);
      end
      ex_cnt = 0;
      dv_cnt = 0;
      b.ex_done = 1'b0;
      for (int i = 1; i < delay; i++) begin
         if (ph == 2'd2) ex_cnt++;
         if (b.de_valid) dv_cnt++;
         @(negedge clk);
      end
      if (ph == 2'd2) ex_cnt++;
      if (b.de_valid) dv_cnt++;
      b.ex_done    = 1'b1;
      b.ex_pc      = npc;
      b.ex_ack     = nack;
      b.ex_tx_req  = ntxr;
      b.ex_tx_data = ntxd;
      e = '{pc: npc, ack: nack, txr: ntxr, txd: ntxd};
      sb.push_back(e);
      @(negedge clk);
      // first WRITEBACK cycle: nothing committed yet, ex_* must be ignored from here on
      b.ex_done = junk;
      if (junk) begin
         b.ex_pc      = ~npc;
         b.ex_tx_data = ~ntxd;
      end
      b.tx_busy = (busy > 0);
      checks++;
      if (ph !== 2'd3 || b.rom_addr !== cur_pc || b.tx_req !== cur_txr || b.tx_data !== cur_txd || b.ack !== cur_ack) begin
         failures++;
         $display("FAIL wb_hold: got ph=%0d pc=%h req=%b dat=%h ack=%b want ph=3 pc=%h req=%b dat=%h ack=%b",
                  ph, b.rom_addr, b.tx_req, b.tx_data, b.ack, cur_pc, cur_txr, cur_txd, cur_ack);
      end
      wb_cnt = 0;
      guard = 0;
      while (ph == 2'd3 && guard < 60) begin
         wb_cnt++;
         if (wb_cnt > busy) b.tx_busy = 1'b0;
         @(negedge clk);
         guard++;
      end
      b.ex_done = 1'b0;
      b.tx_busy = 1'b0;
      wb_exp = (STALL && ntxr) ? busy + 1 : 1;
      checks++;
      if (ex_cnt !== delay || dv_cnt !== 1) begin
         failures++;
         $display("FAIL exec_len: got ex=%0d dv=%0d want ex=%0d dv=1", ex_cnt, dv_cnt, delay);
      end
      checks++;
      if (wb_cnt !== wb_exp || ph !== 2'd0) begin
         failures++;
         $display("FAIL wb_len: got wb=%0d ph=%0d want wb=%0d ph=0", wb_cnt, ph, wb_exp);
      end
      ret_exp++;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL sb_empty: got 0 entries want 1");
      end else begin
         e = sb.pop_front();
         if (b.rom_addr !== e.pc || b.ack !== e.ack || b.tx_req !== e.txr || b.tx_data !== e.txd || ret !== 32'(ret_exp)) begin
            failures++;
            $display("FAIL commit: got pc=%h ack=%b req=%b dat=%h ret=%0d want pc=%h ack=%b req=%b dat=%h ret=%0d",
                     b.rom_addr, b.ack, b.tx_req, b.tx_data, ret, e.pc, e.ack, e.txr, e.txd, ret_exp);
         end
         cur_pc  = e.pc;
         cur_ack = e.ack;
         cur_txr = e.txr;
         cur_txd = e.txd;
      end
   endtask

   task automatic clear_model();
      cur_pc  = '0;
      cur_ack = 1'b0;
      cur_txr = 1'b0;
      cur_txd = '0;
      ret_exp = 0;
      sb.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (ph !== 2'd0 || b.rom_addr !== 11'd0 || ret !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: got ph=%0d pc=%h ret=%0d want 0 0 0", ph, b.rom_addr, ret);
      end
      checks++;
      if ({b.ack, b.tx_req, b.tx_data} !== 10'd0) begin
         failures++;
         $display("FAIL reset_tx: got ack=%b req=%b dat=%h want 0", b.ack, b.tx_req, b.tx_data);
      end
      checks++;
      if ({b.de_opcode, b.de_imm, b.de_irr, b.de_rx_data, b.de_valid} !== 26'd0) begin
         failures++;
         $display("FAIL reset_de: got op=%h imm=%h irr=%b rx=%h v=%b want 0",
                  b.de_opcode, b.de_imm, b.de_irr, b.de_rx_data, b.de_valid);
      end
      clear_model();
      reset = 1'b1;
   endtask

   task automatic test_back_to_back();
      int c0, d0, d1, d2;
      c0 = cyc;
      run_instr(1, 11'd1, 1'b0, 1'b0, 8'h00, 0, 1'b0, d0);
      run_instr(1, 11'd2, 1'b1, 1'b0, 8'h00, 0, 1'b0, d1);
      run_instr(1, 11'd3, 1'b0, 1'b0, 8'h00, 0, 1'b0, d2);
      checks++;
      if (d1 - d0 !== 4 || d2 - d1 !== 4) begin
         failures++;
         $display("FAIL cadence: got %0d,%0d want 4,4", d1 - d0, d2 - d1);
      end
      checks++;
      if (cyc - c0 !== 12 || ret !== 32'd3) begin
         failures++;
         $display("FAIL three_retire: got cycles=%0d ret=%0d want 12 3", cyc - c0, ret);
      end
   endtask

   task automatic test_rom_lat3();
      int n, c1, guard;
      reset3 = 1'b1;
      n = 0;
      while (b3.de_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      c1 = cyc;
      checks++;
      if (n !== 4 || b3.de_opcode !== 4'h5 || b3.de_imm !== 12'hABC) begin
         failures++;
         $display("FAIL lat3_decode: got n=%0d op=%h imm=%h want 4 5 abc", n, b3.de_opcode, b3.de_imm);
      end
      @(negedge clk);
      guard = 0;
      while (b3.de_valid !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (cyc - c1 !== 6 || ret3 !== 32'd1 || b3.rom_addr !== 11'd1) begin
         failures++;
         $display("FAIL lat3_period: got %0d ret=%0d pc=%h want 6 1 001", cyc - c1, ret3, b3.rom_addr);
      end
      reset3 = 1'b0;
   endtask

   task automatic test_exec_delay();
      int d;
      run_instr(5, 11'h010, 1'b1, 1'b0, 8'h00, 0, 1'b0, d);
   endtask

   task automatic test_tx_stall();
      int d;
      run_instr(1, 11'h011, 1'b0, 1'b1, 8'h41, 6, 1'b0, d);
      run_instr(2, 11'h012, 1'b0, 1'b0, 8'h5A, 3, 1'b0, d);
   endtask

   task automatic test_ignore_outside();
      int d;
      run_instr(3, 11'h155, 1'b1, 1'b1, 8'hC3, 0, 1'b1, d);
   endtask

   task automatic test_pc_wrap();
      int d;
      run_instr(1, 11'h7FF, 1'b0, 1'b0, 8'h00, 0, 1'b0, d);
      run_instr(1, 11'h000, 1'b0, 1'b0, 8'h00, 0, 1'b0, d);
   endtask

   task automatic test_reset_mid_exec();
      int guard, d;
      b.ex_done = 1'b0;
      guard = 0;
      while (b.de_valid !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      reset = 1'b0;
      #1;
      checks++;
      if (ph !== 2'd0 || b.rom_addr !== 11'd0 || ret !== 32'd0 || b.de_valid !== 1'b0 ||
          {b.ack, b.tx_req, b.tx_data, b.de_opcode, b.de_imm} !== 26'd0) begin
         failures++;
         $display("FAIL reset_mid_exec: got ph=%0d pc=%h ret=%0d dv=%b req=%b dat=%h op=%h want all 0",
                  ph, b.rom_addr, ret, b.de_valid, b.tx_req, b.tx_data, b.de_opcode);
      end
      clear_model();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      run_instr(1, 11'h0A0, 1'b0, 1'b1, 8'h7E, 0, 1'b0, d);
   endtask

   initial begin
      b.irr = 1'b0;
      b.rx_data = '0;
      b.tx_busy = 1'b0;
      b.ex_done = 1'b0;
      b.ex_pc = '0;
      b.ex_ack = 1'b0;
      b.ex_tx_req = 1'b0;
      b.ex_tx_data = '0;
      clear_model();
      test_rom_lat3();
      test_reset();
      test_back_to_back();
      test_exec_delay();
      test_tx_stall();
      test_ignore_outside();
      test_pc_wrap();
      test_reset_mid_exec();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
